// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants (640x480@60 defaults), control-bit struct and decode helpers.
// Other video modes reuse this by overriding the top-level parameters.
package vga_timing_gen_pkg;

   localparam int unsigned CNT_W = 10;
   localparam int unsigned DIV_W = 2;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_CLK_DIV  = 2;
   localparam int unsigned DEF_PIPE_DLY = 2;

   typedef struct packed {
      logic act;
      logic hs_n;
      logic vs_n;
   } vid_ctl_t;

   localparam vid_ctl_t VID_CTL_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

   function automatic int unsigned span_total(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
      return a + b + c + d;
   endfunction

   function automatic logic in_window(input logic [CNT_W-1:0] v, input int unsigned lo,
                                      input int unsigned len);
      return (32'(v) >= lo) && (32'(v) < lo + len);
   endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// W-bit shift line of depth D advanced on en_i; every stage resets to RST_VAL.
// D=0 degenerates to a wire from d_i to q_o.
module sync_delay #(
   parameter int unsigned W       = 1,
   parameter int unsigned D       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   generate
      if (D == 0) begin : g_pass
         logic unused_ctl;
         assign unused_ctl = ^{clk, rst, en_i};
         assign q_o = d_i;
      end else begin : g_shift
         logic [W-1:0] stage_q [D];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < int'(D); i++) begin
                  stage_q[i] <= RST_VAL;
               end
            end else if (en_i) begin
               stage_q[0] <= d_i;
               for (int i = 1; i < int'(D); i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign q_o = stage_q[D-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, x/y counters, line/frame pulses and
// sync/blank decodes delayed by PIPE_DLY pixels to match the renderer's fetch latency.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned PIPE_DLY = DEF_PIPE_DLY
) (
   input  logic             clk,
   input  logic             rst,
   output logic             pix_en,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             line_start,
   output logic             frame_start,
   output logic             active,
   output logic             hsync,
   output logic             vsync
);

   localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_en_q, pix_en_d;
   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             line_start_q, line_start_d;
   logic             frame_start_q, frame_start_d;
   vid_ctl_t         dec_q, dec_d;
   vid_ctl_t         dly_ctl;
   logic             x_wrap, y_wrap;

   always_comb begin
      div_d         = (div_q == DIV_LAST) ? '0 : div_q + 2'd1;
      pix_en_d      = (div_q == DIV_LAST);
      x_wrap        = pix_en_q && (x_q == H_LAST);
      y_wrap        = x_wrap && (y_q == V_LAST);
      x_d           = x_q;
      y_d           = y_q;
      if (pix_en_q) begin
         x_d = x_wrap ? '0 : x_q + 10'd1;
      end
      if (x_wrap) begin
         y_d = y_wrap ? '0 : y_q + 10'd1;
      end
      line_start_d  = x_wrap;
      frame_start_d = y_wrap;
      // Decode the next count so the registered decode lines up with x/y.
      dec_d.act     = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
      dec_d.hs_n    = !in_window(x_d, H_ACTIVE + H_FP, H_SYNC);
      dec_d.vs_n    = !in_window(y_d, V_ACTIVE + V_FP, V_SYNC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         pix_en_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         dec_q         <= VID_CTL_IDLE;
      end else begin
         div_q         <= div_d;
         pix_en_q      <= pix_en_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         dec_q         <= dec_d;
      end
   end

   sync_delay #(
      .W       ($bits(vid_ctl_t)),
      .D       (PIPE_DLY),
      .RST_VAL (VID_CTL_IDLE)
   ) u_sync_delay (
      .clk  (clk),
      .rst  (rst),
      .en_i (pix_en_q),
      .d_i  (dec_q),
      .q_o  (dly_ctl)
   );

   assign pix_en      = pix_en_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign active      = dly_ctl.act;
   assign hsync       = dly_ctl.hs_n;
   assign vsync       = dly_ctl.vs_n;

endmodule
